ask2_ext_bus_ctrl: RTL and testbench

//  Avalon-MM slave that sequences single read/write cycles on the ASK2 external parallel bus.

---
 rtl/ask2_bus_pkg.sv | 36 +++
 rtl/ask2_ext_bus_ctrl_if.sv | 29 ++
 rtl/ask2_phase_timer.sv | 23 ++
 rtl/ask2_ext_bus_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ask2_ext_bus_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ask2_bus_pkg.sv
// Shared constants and types for the ASK2 external bus controller.
package ask2_bus_pkg;

    // Avalon word offsets
    localparam logic [1:0] REG_TIMING = 2'd0;
    localparam logic [1:0] REG_ADDR   = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // CTRL write bits
    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_CLEAR_BIT = 1;

    // CTRL read (status) bits
    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_DONE_BIT = 1;
    localparam int unsigned STAT_ERR_BIT  = 2;

    // TIMING register layout
    localparam int unsigned TIMING_IRQ_EN_BIT = 12;
    localparam logic [11:0] DEF_TIMING_RST    = 12'h121;

    typedef struct packed {
        logic [3:0] hold;
        logic [3:0] pulse;
        logic [3:0] setup;
    } timing_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StStrobe = 2'd2,
        StHold   = 2'd3
    } bus_state_e;

endpackage

// File: rtl/ask2_ext_bus_ctrl_if.sv
// Avalon-MM slave port plus external parallel bus pins of the ASK2 bus controller.
interface ask2_ext_bus_ctrl_if #(
    parameter int unsigned EXT_AW = 8,
    parameter int unsigned EXT_DW = 8
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;
    logic [EXT_AW-1:0] ext_addr;
    logic [EXT_DW-1:0] ext_data_out;
    logic              ext_data_oe;
    logic [EXT_DW-1:0] ext_data_in;
    logic              ext_ncs;
    logic              ext_nwr;
    logic              ext_nrd;

    modport slave (
        input  address, chipselect, write_n, writedata, ext_data_in,
        output readdata, irq, ext_addr, ext_data_out, ext_data_oe, ext_ncs, ext_nwr, ext_nrd
    );

    modport master (
        output address, chipselect, write_n, writedata, ext_data_in,
        input  readdata, irq, ext_addr, ext_data_out, ext_data_oe, ext_ncs, ext_nwr, ext_nrd
    );
endinterface

// File: rtl/ask2_phase_timer.sv
// 4-bit down counter timing one bus phase; last is high on the phase's final cycle.
module ask2_phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic       last
);
    logic [3:0] cnt_q;

    // Load at phase entry, then count down and park at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else if (load) begin
            cnt_q <= load_value;
        end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign last = (cnt_q == 4'd0);
endmodule

// File: rtl/ask2_ext_bus_ctrl.sv
// Avalon-MM slave sequencing single read/write cycles on the ASK2 external bus.
module ask2_ext_bus_ctrl
    import ask2_bus_pkg::*;
#(
    parameter int unsigned EXT_AW     = 8,
    parameter int unsigned EXT_DW     = 8,
    parameter logic [11:0] DEF_TIMING = DEF_TIMING_RST
) (
    input logic                clk,
    input logic                reset,
    ask2_ext_bus_ctrl_if.slave bus
);
    bus_state_e        state_q, state_d;
    timing_t           timing_q;
    logic              irq_en_q;
    logic [EXT_AW-1:0] addr_reg_q;
    logic [EXT_DW-1:0] data_wr_q;
    logic [EXT_DW-1:0] rdata_q;
    logic              done_q, done_d, err_q, err_d;
    logic              go_q, is_write_q;
    logic [EXT_AW-1:0] ext_addr_q;
    logic [EXT_DW-1:0] ext_data_q;
    logic              ncs_q, nwr_q, nrd_q, oe_q;

    logic              acc, start_wr, start_rd, start_req, start_ok, clear_req, busy;
    logic              load, capture, finish, phase_last;
    logic [3:0]        load_value;
    logic [2:0]        status;
    logic              unused_wdata;

    assign unused_wdata = ^bus.writedata;

    // Decode CPU accesses
    always_comb begin
        acc       = bus.chipselect & ~bus.write_n;
        start_wr  = acc && (bus.address == REG_DATA);
        start_rd  = acc && (bus.address == REG_CTRL) && bus.writedata[CTRL_START_BIT];
        clear_req = acc && (bus.address == REG_CTRL) && bus.writedata[CTRL_CLEAR_BIT];
        // go_q covers the launch cycle before SETUP is entered
        busy      = go_q | (state_q != StIdle);
        start_req = start_wr | start_rd;
        start_ok  = start_req & ~busy;
    end

    // Phase sequencing: each phase loads its field and exits on the timer's last cycle
    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        load_value = 4'd0;
        capture    = 1'b0;
        finish     = 1'b0;
        unique case (state_q)
            StIdle: if (go_q) begin
                state_d    = StSetup;
                load       = 1'b1;
                load_value = timing_q.setup;
            end
            StSetup: if (phase_last) begin
                state_d    = StStrobe;
                load       = 1'b1;
                load_value = timing_q.pulse;
            end
            StStrobe: if (phase_last) begin
                state_d    = StHold;
                load       = 1'b1;
                load_value = timing_q.hold;
                capture    = ~is_write_q;
            end
            StHold: if (phase_last) begin
                state_d = StIdle;
                finish  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Sticky flags: clear first, then set events override
    always_comb begin
        done_d = done_q;
        err_d  = err_q;
        if (clear_req) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (finish) done_d = 1'b1;
        if (start_req && busy) err_d = 1'b1;
    end

    ask2_phase_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .last       (phase_last)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // CPU-visible registers and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            timing_q   <= DEF_TIMING;
            irq_en_q   <= 1'b0;
            addr_reg_q <= '0;
            data_wr_q  <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (acc && (bus.address == REG_TIMING) && !busy) begin
                timing_q <= bus.writedata[11:0];
                irq_en_q <= bus.writedata[TIMING_IRQ_EN_BIT];
            end
            if (acc && (bus.address == REG_ADDR)) addr_reg_q <= bus.writedata[EXT_AW-1:0];
            if (start_ok && start_wr) data_wr_q <= bus.writedata[EXT_DW-1:0];
            if (capture) rdata_q <= bus.ext_data_in;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    // Launch: snapshot address/data and direction on the accepted start edge
    always_ff @(posedge clk) begin
        if (reset) begin
            go_q       <= 1'b0;
            is_write_q <= 1'b0;
            ext_addr_q <= '0;
            ext_data_q <= '0;
        end else begin
            go_q <= start_ok;
            if (start_ok) begin
                is_write_q <= start_wr;
                ext_addr_q <= addr_reg_q;
                ext_data_q <= start_wr ? bus.writedata[EXT_DW-1:0] : data_wr_q;
            end
        end
    end

    // Pin flops follow the next state so strobes line up with phase boundaries
    always_ff @(posedge clk) begin
        if (reset) begin
            ncs_q <= 1'b1;
            nwr_q <= 1'b1;
            nrd_q <= 1'b1;
            oe_q  <= 1'b0;
        end else begin
            ncs_q <= (state_d == StIdle);
            nwr_q <= !((state_d == StStrobe) && is_write_q);
            nrd_q <= !((state_d == StStrobe) && !is_write_q);
            oe_q  <= (state_d != StIdle) && is_write_q;
        end
    end

    // Register readback, zero for unmapped bits
    always_comb begin
        status                = '0;
        status[STAT_BUSY_BIT] = busy;
        status[STAT_DONE_BIT] = done_q;
        status[STAT_ERR_BIT]  = err_q;
        bus.readdata          = '0;
        case (bus.address)
            REG_TIMING: bus.readdata[12:0]       = {irq_en_q, timing_q};
            REG_ADDR:   bus.readdata[EXT_AW-1:0] = addr_reg_q;
            REG_DATA:   bus.readdata[EXT_DW-1:0] = rdata_q;
            default:    bus.readdata[2:0]        = status;
        endcase
    end

    assign bus.irq          = done_q & irq_en_q;
    assign bus.ext_addr     = ext_addr_q;
    assign bus.ext_data_out = ext_data_q;
    assign bus.ext_data_oe  = oe_q;
    assign bus.ext_ncs      = ncs_q;
    assign bus.ext_nwr      = nwr_q;
    assign bus.ext_nrd      = nrd_q;
endmodule

// File: tb/tb_ask2_ext_bus_ctrl.sv
// Bench for ask2_ext_bus_ctrl: transaction-schedule model checked every cycle plus literal checks.
module tb_ask2_ext_bus_ctrl;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ask2_ext_bus_ctrl_if #(.EXT_AW(8), .EXT_DW(8)) bus ();

    ask2_ext_bus_ctrl #(
        .EXT_AW     (8),
        .EXT_DW     (8),
        .DEF_TIMING (12'h121)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: a cycle accepted at edge t0 runs with phases S/P/H, ncs low t0+1..t0+S+P+H+3
    int          cyc = 0;
    bit          m_act;
    int          t0, ms, mp, mh;
    bit          m_wr;
    logic [7:0]  m_ext_addr, m_ext_data, m_addr_reg, m_data_reg, m_rdata;
    logic [11:0] m_timing;
    bit          m_irq_en, m_done, m_err;

    // Observed pin activity
    int ncs_lo, nwr_lo, nrd_lo, nwr_pulses, first_ncs, first_nwr;
    bit prev_nwr = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_act = 0; t0 = 0; ms = 0; mp = 0; mh = 0; m_wr = 0;
        m_ext_addr = '0; m_ext_data = '0; m_addr_reg = '0; m_data_reg = '0; m_rdata = '0;
        m_timing = 12'h121; m_irq_en = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_edge();
        bit          busy_pre, acc, st_w, st_r;
        logic [31:0] wd;
        cyc++;
        if (reset) begin
            model_reset();
            return;
        end
        busy_pre = m_act;
        acc  = bus.chipselect && !bus.write_n;
        wd   = bus.writedata;
        st_w = acc && (bus.address == 2'd2);
        st_r = acc && (bus.address == 2'd3) && wd[0];
        if (m_act && !m_wr && (cyc == t0 + ms + mp + 3)) m_rdata = bus.ext_data_in;
        if (acc && (bus.address == 2'd3) && wd[1]) begin
            m_done = 0;
            m_err  = 0;
        end
        if (m_act && (cyc == t0 + ms + mp + mh + 4)) begin
            m_done = 1;
            m_act  = 0;
        end
        if (st_w || st_r) begin
            if (busy_pre) begin
                m_err = 1;
            end else begin
                m_act = 1; t0 = cyc; m_wr = st_w;
                ms = int'(m_timing[3:0]); mp = int'(m_timing[7:4]); mh = int'(m_timing[11:8]);
                m_ext_addr = m_addr_reg;
                m_ext_data = st_w ? wd[7:0] : m_data_reg;
                if (st_w) m_data_reg = wd[7:0];
            end
        end
        if (acc && (bus.address == 2'd0) && !busy_pre) {m_irq_en, m_timing} = wd[12:0];
        if (acc && (bus.address == 2'd1)) m_addr_reg = wd[7:0];
    endtask

    task automatic compare();
        bit          in_cyc, strb;
        logic [31:0] exp_rd;
        in_cyc = m_act && (cyc >= t0 + 1);
        strb   = in_cyc && (cyc >= t0 + ms + 2) && (cyc <= t0 + ms + mp + 2);
        case (bus.address)
            2'd0:    exp_rd = {19'b0, m_irq_en, m_timing};
            2'd1:    exp_rd = {24'b0, m_addr_reg};
            2'd2:    exp_rd = {24'b0, m_rdata};
            default: exp_rd = {29'b0, m_err, m_done, m_act};
        endcase
        check("ncs", bus.ext_ncs, !in_cyc);
        check("nwr", bus.ext_nwr, !(strb && m_wr));
        check("nrd", bus.ext_nrd, !(strb && !m_wr));
        check("oe", bus.ext_data_oe, in_cyc && m_wr);
        check("ext_addr", bus.ext_addr, m_ext_addr);
        check("ext_data_out", bus.ext_data_out, m_ext_data);
        check("readdata", bus.readdata, exp_rd);
        check("irq", bus.irq, m_done && m_irq_en);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
        if (!bus.ext_ncs) begin
            ncs_lo++;
            if (first_ncs < 0) first_ncs = cyc;
        end
        if (!bus.ext_nwr) begin
            nwr_lo++;
            if (first_nwr < 0) first_nwr = cyc;
            if (prev_nwr) nwr_pulses++;
        end
        if (!bus.ext_nrd) nrd_lo++;
        prev_nwr = bus.ext_nwr;
    endtask

    task automatic clr_cnt();
        ncs_lo = 0; nwr_lo = 0; nrd_lo = 0; nwr_pulses = 0; first_ncs = -1; first_nwr = -1;
    endtask

    task automatic idle(input int n);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        repeat (n) tick();
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd_reg(input logic [1:0] a, input logic [31:0] exp, input string name);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        tick();
        check(name, bus.readdata, exp);
        bus.chipselect = 1'b0;
    endtask

    initial begin
        int s0;
        model_reset();
        clr_cnt();
        reset          = 1'b1;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        bus.ext_data_in = '0;
        repeat (2) tick();
        reset = 1'b0;

        // Reset values
        check("rst_ncs", bus.ext_ncs, 1);
        check("rst_nwr", bus.ext_nwr, 1);
        check("rst_nrd", bus.ext_nrd, 1);
        check("rst_oe", bus.ext_data_oe, 0);
        rd_reg(2'd0, 32'h121, "rst_timing");
        rd_reg(2'd1, 32'h0, "rst_addr");
        rd_reg(2'd3, 32'h0, "rst_status");

        // Default-timing write cycle
        wr_reg(2'd1, 32'h3C);
        clr_cnt();
        wr_reg(2'd2, 32'hA5);
        s0 = cyc;
        idle(10);
        check("wr_first_ncs", first_ncs - s0, 1);
        check("wr_first_nwr", first_nwr - s0, 3);
        check("wr_ncs_len", ncs_lo, 7);
        check("wr_nwr_len", nwr_lo, 3);
        check("wr_ext_addr", bus.ext_addr, 8'h3C);
        check("wr_ext_data", bus.ext_data_out, 8'hA5);
        rd_reg(2'd3, 32'b010, "wr_status");

        // Minimum-timing read cycle
        wr_reg(2'd0, 32'h000);
        bus.ext_data_in = 8'h5A;
        clr_cnt();
        wr_reg(2'd3, 32'h1);
        idle(6);
        check("rd_ncs_len", ncs_lo, 3);
        check("rd_nrd_len", nrd_lo, 1);
        check("rd_nwr_len", nwr_lo, 0);
        rd_reg(2'd2, 32'h5A, "rd_data");
        rd_reg(2'd3, 32'b010, "rd_status");

        // Start while busy is rejected
        bus.ext_data_in = 8'h00;
        clr_cnt();
        wr_reg(2'd2, 32'h11);
        wr_reg(2'd2, 32'h22);
        idle(6);
        check("busy_nwr_pulses", nwr_pulses, 1);
        check("busy_ext_data", bus.ext_data_out, 8'h11);
        rd_reg(2'd3, 32'b110, "busy_status_err");
        wr_reg(2'd3, 32'h2);
        rd_reg(2'd3, 32'h0, "busy_status_cleared");

        // Interrupt, then clear-and-read in one write
        wr_reg(2'd0, 32'h1121);
        check("irq_idle", bus.irq, 0);
        bus.ext_data_in = 8'hC3;
        wr_reg(2'd2, 32'h77);
        idle(6);
        check("irq_before_done", bus.irq, 0);
        idle(2);
        check("irq_at_done", bus.irq, 1);
        wr_reg(2'd3, 32'h3);
        check("irq_cleared", bus.irq, 0);
        rd_reg(2'd3, 32'b001, "clr_start_busy");
        idle(12);
        rd_reg(2'd2, 32'hC3, "clr_start_rdata");

        // Reset during STROBE
        wr_reg(2'd2, 32'h5C);
        idle(3);
        check("strobe_before_reset", bus.ext_nwr, 0);
        reset       = 1'b1;
        bus.address = 2'd3;
        tick();
        reset = 1'b0;
        check("mid_rst_ncs", bus.ext_ncs, 1);
        check("mid_rst_nwr", bus.ext_nwr, 1);
        check("mid_rst_nrd", bus.ext_nrd, 1);
        check("mid_rst_oe", bus.ext_data_oe, 0);
        check("mid_rst_status", bus.readdata, 0);
        idle(10);
        rd_reg(2'd3, 32'h0, "mid_rst_no_done");
        rd_reg(2'd0, 32'h121, "mid_rst_timing");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
